// File: rtl/puf_race_sequencer_pkg.sv
// Shared definitions for the PUF race sequencer: state encoding, CLEAR length, default widths.
// Optional timeout supervision is enabled by defining PUF_SEQ_TIMEOUT_EN.
package puf_race_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_CLEAR  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_RACE   = 3'd3,
      ST_RECORD = 3'd4,
      ST_DONE   = 3'd5
   } seq_state_e;

   // Two cycles so the counters' registered finished flags are flushed too
   localparam int CLEAR_CYC       = 2;

   localparam int DEF_N_BITS      = 32;
   localparam int DEF_CW          = 8;
   localparam int DEF_SETTLE_CYC  = 16;
   localparam int DEF_TIMEOUT_CYC = 4096;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/puf_race_sequencer_if.sv
// Bundle between the run controller, the race sequencer and the post-mux counter datapath.
interface puf_race_sequencer_if
   import puf_race_sequencer_pkg::*;
#(
   parameter int N_BITS = DEF_N_BITS,
   parameter int CW     = DEF_CW
) ();

   logic              start;
   logic [CW-1:0]     challenge_base;
   logic              busy;
   logic              done;
   logic [N_BITS-1:0] response;
   logic [CW-1:0]     challenge;
   logic              ctr_reset;
   logic              ctr_enable;
   logic              finished_a;
   logic              finished_b;
   logic              tie;
   logic              timeout_err;

   modport master (
      output start, challenge_base, finished_a, finished_b,
      input  busy, done, response, challenge, ctr_reset, ctr_enable, tie, timeout_err
   );

   modport slave (
      input  start, challenge_base, finished_a, finished_b,
      output busy, done, response, challenge, ctr_reset, ctr_enable, tie, timeout_err
   );

endinterface

// File: rtl/puf_race_sequencer_timer.sv
// Loadable down-counter with a zero flag; paces CLEAR, SETTLE and the optional RACE timeout.
module puf_wait_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

// File: rtl/puf_race_sequencer.sv
// Sequences one RO-PUF evaluation of N_BITS bits by racing two post-mux counters per challenge.
// Define PUF_SEQ_TIMEOUT_EN to abort a race after TIMEOUT_CYC cycles (bit=0, timeout_err set).
module puf_race_sequencer
   import puf_race_sequencer_pkg::*;
#(
   parameter int N_BITS      = DEF_N_BITS,
   parameter int CW          = DEF_CW,
   parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
   input  logic               clk,
   input  logic               reset,
   puf_race_sequencer_if.slave bus
);

   localparam int IW = $clog2(N_BITS) + 1;
`ifdef PUF_SEQ_TIMEOUT_EN
   localparam int TMAX = max_int(max_int(CLEAR_CYC, SETTLE_CYC), TIMEOUT_CYC);
`else
   localparam int TMAX = max_int(CLEAR_CYC, SETTLE_CYC);
`endif
   localparam int TW = $clog2(TMAX) + 1;

   seq_state_e        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [CW-1:0]     challenge_q, challenge_d;
   logic [N_BITS-1:0] response_q, response_d;
   logic              race_bit_q, race_bit_d;
   logic              tie_q, tie_d;
   logic              timeout_err_q, timeout_err_d;

   logic              timer_load;
   logic [TW-1:0]     timer_val;
   logic              timer_dec;
   logic              timer_zero;

   puf_wait_timer #(
      .W (TW)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .dec      (timer_dec),
      .zero     (timer_zero)
   );

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      challenge_d   = challenge_q;
      response_d    = response_q;
      race_bit_d    = race_bit_q;
      tie_d         = tie_q;
      timeout_err_d = timeout_err_q;
      timer_load    = 1'b0;
      timer_val     = '0;
      timer_dec     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               challenge_d   = bus.challenge_base;
               idx_d         = '0;
               response_d    = '0;
               tie_d         = 1'b0;
               timeout_err_d = 1'b0;
               timer_load    = 1'b1;
               timer_val     = TW'(CLEAR_CYC - 1);
               state_d       = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            if (timer_zero) begin
               timer_load = 1'b1;
               timer_val  = TW'(SETTLE_CYC - 1);
               state_d    = ST_SETTLE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (timer_zero) begin
`ifdef PUF_SEQ_TIMEOUT_EN
               timer_load = 1'b1;
               timer_val  = TW'(TIMEOUT_CYC - 1);
`endif
               state_d = ST_RACE;
            end else begin
               timer_dec = 1'b1;
            end
         end
         ST_RACE: begin
            // A alone wins as 1; B alone or a simultaneous finish records 0
            if (bus.finished_a || bus.finished_b) begin
               race_bit_d = bus.finished_a & ~bus.finished_b;
               if (bus.finished_a && bus.finished_b) begin
                  tie_d = 1'b1;
               end
               state_d = ST_RECORD;
            end
`ifdef PUF_SEQ_TIMEOUT_EN
            else if (timer_zero) begin
               race_bit_d    = 1'b0;
               timeout_err_d = 1'b1;
               state_d       = ST_RECORD;
            end else begin
               timer_dec = 1'b1;
            end
`endif
         end
         ST_RECORD: begin
            for (int i = 0; i < N_BITS; i++) begin
               if (idx_q == IW'(i)) begin
                  response_d[i] = race_bit_q;
               end
            end
            if (idx_q == IW'(N_BITS - 1)) begin
               state_d = ST_DONE;
            end else begin
               idx_d       = idx_q + IW'(1);
               challenge_d = challenge_q + CW'(1);
               timer_load  = 1'b1;
               timer_val   = TW'(CLEAR_CYC - 1);
               state_d     = ST_CLEAR;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         idx_q         <= '0;
         challenge_q   <= '0;
         response_q    <= '0;
         race_bit_q    <= 1'b0;
         tie_q         <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         challenge_q   <= challenge_d;
         response_q    <= response_d;
         race_bit_q    <= race_bit_d;
         tie_q         <= tie_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   // Control outputs decode straight from state so an async reset takes effect immediately
   assign bus.busy        = (state_q != ST_IDLE);
   assign bus.done        = (state_q == ST_DONE);
   assign bus.ctr_reset   = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
   assign bus.ctr_enable  = (state_q == ST_RACE);
   assign bus.challenge   = challenge_q;
   assign bus.response    = response_q;
   assign bus.tie         = tie_q;
`ifdef PUF_SEQ_TIMEOUT_EN
   assign bus.timeout_err = timeout_err_q;
`else
   assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_puf_race_sequencer.sv
// Directed bench for puf_race_sequencer: behavioural counter pair with per-bit goals.
module tb_puf_race_sequencer;

   localparam int N  = 4;
   localparam int CW = 8;
   localparam int SC = 4;
   localparam int TC = 20;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   puf_race_sequencer_if #(.N_BITS(N), .CW(CW)) bus ();

   puf_race_sequencer #(
      .N_BITS      (N),
      .CW          (CW),
      .SETTLE_CYC  (SC),
      .TIMEOUT_CYC (TC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Counter environment: goal 0 means that counter never finishes
   logic [15:0] goal_a [4];
   logic [15:0] goal_b [4];
   logic [7:0]  base_t = 8'h00;
   logic [7:0]  off;
   logic [15:0] cnt_a = 16'd0;
   logic [15:0] cnt_b = 16'd0;

   assign off = bus.challenge - base_t;
   assign bus.finished_a = (goal_a[off[1:0]] != 16'd0) && (cnt_a >= goal_a[off[1:0]]);
   assign bus.finished_b = (goal_b[off[1:0]] != 16'd0) && (cnt_b >= goal_b[off[1:0]]);

   always @(posedge clk) begin
      if (bus.ctr_reset) begin
         cnt_a <= 16'd0;
         cnt_b <= 16'd0;
      end else if (bus.ctr_enable) begin
         cnt_a <= cnt_a + 16'd1;
         cnt_b <= cnt_b + 16'd1;
      end
   end

   // Monitor: settle gap per bit, challenge at each race start, done pulses
   int         cyc = 0;
   int         t_fall = 0;
   int         done_cnt = 0;
   logic       prev_cr = 1'b1;
   logic       prev_ce = 1'b0;
   logic [7:0] ch_seen [$];

   always @(negedge clk) begin
      cyc++;
      if (prev_cr && !bus.ctr_reset) t_fall = cyc;
      if (!prev_ce && bus.ctr_enable) begin
         check("settle_gap", 32'(cyc - t_fall), SC);
         ch_seen.push_back(bus.challenge);
      end
      if (bus.done) done_cnt++;
      prev_cr = bus.ctr_reset;
      prev_ce = bus.ctr_enable;
   end

   task automatic set_goals(input int a0, input int b0, input int a1, input int b1,
                            input int a2, input int b2, input int a3, input int b3);
      goal_a[0] = 16'(a0); goal_b[0] = 16'(b0);
      goal_a[1] = 16'(a1); goal_b[1] = 16'(b1);
      goal_a[2] = 16'(a2); goal_b[2] = 16'(b2);
      goal_a[3] = 16'(a3); goal_b[3] = 16'(b3);
   endtask

   task automatic start_run(input logic [7:0] base);
      @(negedge clk);
      base_t = base;
      ch_seen.delete();
      done_cnt = 0;
      bus.challenge_base = base;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.challenge_base = 8'hAA;
   endtask

   task automatic wait_done();
      int k = 0;
      while (!bus.done && k < 2000) begin
         @(negedge clk);
         k++;
      end
      check("done_seen", 32'(bus.done), 1);
      @(negedge clk);
      @(negedge clk);
      check("done_once", 32'(done_cnt), 1);
      check("busy_after", 32'(bus.busy), 0);
   endtask

   task automatic check_run(input string name, input logic [7:0] base, input logic [3:0] exp_resp,
                            input logic exp_tie, input logic exp_to);
      logic [7:0] e;
      check({name, "_resp"}, 32'(bus.response), 32'(exp_resp));
      check({name, "_tie"}, 32'(bus.tie), 32'(exp_tie));
      check({name, "_timeout"}, 32'(bus.timeout_err), 32'(exp_to));
      check({name, "_nbits"}, 32'(ch_seen.size()), N);
      for (int i = 0; i < N; i++) begin
         e = base + 8'(i);
         if (i < ch_seen.size()) check({name, "_chal"}, 32'(ch_seen[i]), 32'(e));
      end
      $display("run %s base=0x%02h response=%b tie=%0b timeout_err=%0b", name, base,
               bus.response, bus.tie, bus.timeout_err);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int   k;
      logic found;
      bus.start = 1'b0;
      bus.challenge_base = 8'h00;
      set_goals(1, 3, 1, 3, 1, 3, 1, 3);

      // Reset state
      @(negedge clk);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_ctr_reset", 32'(bus.ctr_reset), 1);
      check("rst_ctr_enable", 32'(bus.ctr_enable), 0);
      check("rst_response", 32'(bus.response), 0);
      check("rst_challenge", 32'(bus.challenge), 0);
      check("rst_tie", 32'(bus.tie), 0);
      check("rst_timeout", 32'(bus.timeout_err), 0);
      reset = 1'b0;

      // 1: A always first
      set_goals(1, 3, 1, 3, 1, 3, 1, 3);
      start_run(8'h10);
      check("t1_busy", 32'(bus.busy), 1);
      wait_done();
      check_run("t1", 8'h10, 4'b1111, 1'b0, 1'b0);

      // 2: winners B,A,B,A
      set_goals(3, 1, 1, 3, 3, 1, 1, 3);
      start_run(8'h20);
      wait_done();
      check_run("t2", 8'h20, 4'b1010, 1'b0, 1'b0);

      // 3: tie on bit 2
      set_goals(1, 3, 1, 3, 2, 2, 1, 3);
      start_run(8'h24);
      wait_done();
      check_run("t3", 8'h24, 4'b1011, 1'b1, 1'b0);

      // 4: start during race of bit 1 is ignored
      set_goals(5, 8, 5, 8, 5, 8, 5, 8);
      start_run(8'h30);
      check("t4_tie_cleared", 32'(bus.tie), 0);
      k = 0;
      found = 1'b0;
      while (!found && k < 500) begin
         @(negedge clk);
         k++;
         if (bus.ctr_enable && bus.challenge == 8'h31) found = 1'b1;
      end
      check("t4_reach_race1", 32'(found), 1);
      bus.challenge_base = 8'h99;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("t4_busy_held", 32'(bus.busy), 1);
      check("t4_chal_held", 32'(bus.challenge), 32'h31);
      wait_done();
      check_run("t4", 8'h30, 4'b1111, 1'b0, 1'b0);

      // 5: async reset in SETTLE of bit 3, then a clean run
      set_goals(1, 3, 1, 3, 1, 3, 1, 3);
      start_run(8'h40);
      k = 0;
      found = 1'b0;
      while (!found && k < 500) begin
         @(negedge clk);
         k++;
         if (bus.busy && bus.challenge == 8'h43 && !bus.ctr_reset && !bus.ctr_enable) found = 1'b1;
      end
      check("t5_reach_settle3", 32'(found), 1);
      check("t5_partial", 32'(bus.response), 32'h7);
      #2 reset = 1'b1;
      #1;
      check("t5_busy", 32'(bus.busy), 0);
      check("t5_response", 32'(bus.response), 0);
      check("t5_ctr_reset", 32'(bus.ctr_reset), 1);
      check("t5_ctr_enable", 32'(bus.ctr_enable), 0);
      check("t5_challenge", 32'(bus.challenge), 0);
      @(negedge clk);
      reset = 1'b0;
      set_goals(3, 1, 1, 3, 1, 3, 1, 3);
      start_run(8'h50);
      wait_done();
      check_run("t5", 8'h50, 4'b1110, 1'b0, 1'b0);

      // 6: challenge wrap, plus timeout on bit 0 when supervision is built in
`ifdef PUF_SEQ_TIMEOUT_EN
      set_goals(0, 0, 1, 3, 1, 3, 1, 3);
      start_run(8'hFE);
      wait_done();
      check_run("t6", 8'hFE, 4'b1110, 1'b0, 1'b1);
`else
      set_goals(1, 3, 1, 3, 1, 3, 1, 3);
      start_run(8'hFE);
      wait_done();
      check_run("t6", 8'hFE, 4'b1111, 1'b0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
